// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data memory between the core load/store path (port 0) and a
// debug/program-loader requester (port 1). At most one port is granted per
// cycle; contention is resolved round-robin, and port 1 may hold priority for
// up to MAX_BURST consecutive grants while port 0 waits. Read data returns
// registered, one cycle after the grant.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   m0_* / m1_*            requester ports: req, we, addr, wdata in;
//                          gnt, rvalid, rdata out
//   m1_lock                port 1 asks to keep priority on following cycles
//   mem_a, mem_we, mem_wd  memory address, write enable, write data
//   mem_rd                 memory read data (combinational from mem_a)

module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    logic          last;       // port granted in the most recent contention cycle
    logic          locked;
    logic [CW-1:0] burst_cnt;
    logic          rd_port;
    logic          rd_pend;
    logic [DW-1:0] rdata_q;

    logic gnt0;
    logic gnt1;

    // Grants are gated by reset so nothing reaches the memory while held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (m0_req && m1_req) begin
                if (locked && (burst_cnt < CNT_MAX)) begin
                    gnt1 = 1'b1;
                end else if (locked) begin
                    // burst exhausted: port 0 gets exactly one slot
                    gnt0 = 1'b1;
                end else if (last) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Idle cycles present port 0's address/data so the bus is never floating.
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (rst) begin
            if (gnt1) begin
                mem_a  = m1_addr;
                mem_wd = m1_wdata;
                mem_we = m1_we;
            end else begin
                mem_a  = m0_addr;
                mem_wd = m0_wdata;
                mem_we = gnt0 & m0_we;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last      <= 1'b1;
            locked    <= 1'b0;
            burst_cnt <= '0;
            rd_port   <= 1'b0;
            rd_pend   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // Port 1 alone keeps counting but saturates, so it is never starved.
            if (gnt1 && m1_lock) begin
                locked <= 1'b1;
                if (burst_cnt != CNT_MAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                locked    <= 1'b0;
                burst_cnt <= '0;
            end

            if (m0_req && m1_req) begin
                last <= gnt1;
            end

            if ((gnt0 && !m0_we) || (gnt1 && !m1_we)) begin
                rdata_q <= mem_rd;
                rd_port <= gnt1;
                rd_pend <= 1'b1;
            end else begin
                rd_pend <= 1'b0;
            end
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rst & rd_pend & ~rd_port;
    assign m1_rvalid = rst & rd_pend & rd_port;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Small word memory: combinational read, write at the granting edge.
    logic [31:0] mem [0:15];
    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    assign mem_rd = mem[mem_a[5:2]];

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        lk;
        logic        g0, g1, we;
        logic [31:0] ea;
        logic        v0, v1, chk;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D = 32'hDEADBEEF;
    localparam logic [31:0] P = 32'h11111111;
    localparam logic [31:0] Q = 32'h22222222;

    task automatic add(input logic rs, input logic r0, input logic w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1, input logic lk,
                       input logic g0, input logic g1, input logic we,
                       input logic [31:0] ea, input logic v0, input logic v1,
                       input logic chk, input logic [31:0] erd);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.lk = lk;
        v.g0 = g0; v.g1 = g1; v.we = we; v.ea = ea;
        v.v0 = v0; v.v1 = v1; v.chk = chk; v.erd = erd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset held with both requesting
        add(0, 1,1,32'h10,D, 1,1,32'h20,Q, 0,  0,0,0,32'h0,  0,0,0,0);
        add(0, 1,1,32'h10,D, 1,1,32'h20,Q, 0,  0,0,0,32'h0,  0,0,0,0);
        // release: first contention goes to port 0 (m0 write wins)
        add(1, 1,1,32'h10,D, 1,0,32'h20,0, 0,  1,0,1,32'h10, 0,0,0,0);
        add(1, 1,0,32'h10,0, 0,0,32'h20,0, 0,  1,0,0,32'h10, 0,0,0,0);
        add(1, 0,0,32'h10,0, 0,0,32'h20,0, 0,  0,0,0,32'h10, 1,0,1,D);
        // round-robin, last=0 so port 1 first
        for (int i = 0; i < 6; i++)
            add(1, 1,1,32'h14,P, 1,1,32'h18,Q, 0,
                (i % 2) == 1, (i % 2) == 0, 1, ((i % 2) == 1) ? 32'h14 : 32'h18, 0,0,0,0);
        // locked burst: 1,1,1,1,0,1,1,1,1,0
        for (int i = 0; i < 10; i++)
            add(1, 1,1,32'h14,P, 1,1,32'h18,Q, 1,
                (i % 5) == 4, (i % 5) != 4, 1, ((i % 5) == 4) ? 32'h14 : 32'h18, 0,0,0,0);
        // lock dropped: alternation resumes
        add(1, 1,1,32'h14,P, 1,1,32'h18,Q, 0,  0,1,1,32'h18, 0,0,0,0);
        add(1, 1,1,32'h14,P, 1,1,32'h18,Q, 0,  1,0,1,32'h14, 0,0,0,0);
        add(1, 1,1,32'h14,P, 1,1,32'h18,Q, 0,  0,1,1,32'h18, 0,0,0,0);
        // m1 read, then m0 read coinciding with m1 rvalid
        add(1, 0,0,32'h10,0, 1,0,32'h18,0, 0,  0,1,0,32'h18, 0,0,0,0);
        add(1, 1,0,32'h10,0, 0,0,32'h18,0, 0,  1,0,0,32'h10, 0,1,1,Q);
        add(1, 0,0,32'h10,0, 0,0,32'h18,0, 0,  0,0,0,32'h10, 1,0,1,D);
        // port 1 alone with lock: granted every cycle, no forced gap
        for (int i = 0; i < 10; i++)
            add(1, 0,0,32'h10,0, 1,1,32'h18,Q, 1,  0,1,1,32'h18, 0,0,0,0);
        // saturated burst: port 0 arriving wins immediately
        add(1, 1,0,32'h14,0, 1,1,32'h18,Q, 1,  1,0,0,32'h14, 0,0,0,0);
        add(1, 0,0,32'h10,0, 0,0,32'h18,0, 0,  0,0,0,32'h10, 1,0,1,P);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            m0_req = vecs[i].r0; m0_we = vecs[i].w0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
            m1_req = vecs[i].r1; m1_we = vecs[i].w1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
            m1_lock = vecs[i].lk;
            #1;
            check("m0_gnt", i, {31'b0, m0_gnt}, {31'b0, vecs[i].g0});
            check("m1_gnt", i, {31'b0, m1_gnt}, {31'b0, vecs[i].g1});
            check("one_gnt", i, {31'b0, m0_gnt & m1_gnt}, 32'h0);
            check("mem_we", i, {31'b0, mem_we}, {31'b0, vecs[i].we});
            check("mem_a", i, mem_a, vecs[i].ea);
            check("m0_rvalid", i, {31'b0, m0_rvalid}, {31'b0, vecs[i].v0});
            check("m1_rvalid", i, {31'b0, m1_rvalid}, {31'b0, vecs[i].v1});
            if (vecs[i].chk) begin
                check("m0_rdata", i, m0_rdata, vecs[i].erd);
                check("m1_rdata", i, m1_rdata, vecs[i].erd);
            end
            if (!vecs[i].rst) check("mem_wd", i, mem_wd, 32'h0);
            @(negedge clk);
        end

        // Reset mid-read: m1 read granted, reset before the edge
        rst = 1; m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 32'h18; m1_lock = 0;
        #1;
        check("rmr_gnt", 100, {31'b0, m1_gnt}, 32'h1);
        #2 rst = 0;
        #1;
        check("rmr_gnt_rst", 101, {31'b0, m1_gnt}, 32'h0);
        check("rmr_we_rst", 101, {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        check("rmr_rv_rst", 102, {31'b0, m1_rvalid}, 32'h0);
        rst = 1; m1_req = 0;
        #1;
        check("rmr_rv_rel", 103, {31'b0, m1_rvalid | m0_rvalid}, 32'h0);
        @(negedge clk);
        #1;
        check("rmr_rv_rel2", 104, {31'b0, m1_rvalid | m0_rvalid}, 32'h0);
        // last restored to 1: port 0 wins the first contention
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m1_req = 1;
        #1;
        check("rmr_first_g0", 105, {31'b0, m0_gnt}, 32'h1);
        check("rmr_first_g1", 105, {31'b0, m1_gnt}, 32'h0);
        @(negedge clk);
        m0_req = 0; m1_req = 0;
        #1;
        check("rmr_rd_after", 106, {31'b0, m0_rvalid}, 32'h1);
        check("rmr_rdata", 106, m0_rdata, D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the core's load/store path (port 0) and a debug/program-loader requester (port 1). It sits between the core's ALU-address/RD2 write-data path and the data memory. Each cycle it grants at most one requester, drives the memory address, write-enable and write-data, and returns registered read data to the granted port one cycle later. Contention is resolved round-robin. Port 1 may lock the memory for a bounded burst.

## Interface

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 4, max consecutive locked port-1 grants while port 0 waits (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- m0_req  in  1  port 0 (core) request
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  AW  port 0 byte address
- m0_wdata  in  DW  port 0 write data
- m0_gnt  out  1  port 0 granted this cycle (m0_req & !m0_gnt = core stall)
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DW  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: as port 0, for port 1
- m1_lock  in  1  port 1 requests to keep priority on following cycles
- mem_a  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory read data (combinational from mem_a)

## Operation

- State: last (1 b, last port granted under contention), burst_cnt (ceil(log2(MAX_BURST+1)) b), locked (1 b), rd_port/rd_pend (pending read return), rdata_q (DW).
- Grant (combinational from req inputs and registered state):
  - neither req: no grant; mem_we=0; mem_a/mem_wd = port 0 values.
  - one req: that port granted.
  - both: if locked and burst_cnt < MAX_BURST → port 1; else if locked and burst_cnt == MAX_BURST → port 0; else port ≠ last.
- At most one gnt high per cycle. mem_a/mem_wd muxed from granted port; mem_we = granted port's we.
- Lock bookkeeping at each edge:
  - m1 granted & m1_lock: locked←1; burst_cnt←burst_cnt+1, saturating at MAX_BURST.
  - Otherwise: locked←0, burst_cnt←0.
  - Lock only counts against port 0 when port 0 is requesting; port 1 alone is always granted.
- last updates only in a contention cycle, to the granted port.
- Granted read (gnt & !we): at the edge, rdata_q←mem_rd, rd_port←port, rd_pend←1; otherwise rd_pend←0.
- Granted write: memory writes at the same edge; no rvalid.
- mX_rvalid = rd_pend & (rd_port==X). mX_rdata = rdata_q for both ports (qualify with rvalid).
- Requesters hold req/we/addr/wdata stable until gnt is seen high. Dropping req without gnt is legal and has no side effect.

## Timing

- Grant: same cycle as req (combinational); write commits at the granting edge.
- Read latency: 1 cycle. rvalid is high for exactly one cycle, the cycle after the grant.
- Back-to-back grants to the same port are allowed every cycle. rvalid and a new gnt may coincide.
- Reset (rst=0, async): last←1 (port 0 wins first contention), locked←0, burst_cnt←0, rd_pend←0, rdata_q←0.
  - While rst=0, all gnt, rvalid and mem_we are forced 0; mem_a = 0; mem_wd = 0.
- Reset mid-read: pending rvalid is discarded and does not appear after release.
- First edge after rst rises behaves as from IDLE.
- Lock with MAX_BURST=N under continuous contention: port 1 gets N consecutive grants, then port 0 gets 1. Lock then restarts if m1_lock is still high.

## Test plan

- Reset: hold rst=0 with both req=1 → all gnt=0, mem_we=0, rvalid=0. Release → first cycle m0_gnt=1 (last=1).
- Port 0 write then read: m0 write addr 0x10 data 0xDEADBEEF, then read 0x10 → m0_gnt=1 both cycles; m0_rvalid=1 one cycle after the read with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Contention round-robin: both req, lock=0, for 6 cycles → grants alternate 0,1,0,1,0,1; m0_gnt and m1_gnt never both 1.
- Locked burst, MAX_BURST=4:
  - both req continuously, m1_lock=1, port 1 granted first → grants 1,1,1,1,0,1,1,1,1,0.
  - m1_lock drops → reverts to alternation.
- Reset mid-read: m1 read granted, rst=0 asserted before the next edge → m1_rvalid never asserts; after release rd_pend=0.
- Single requester starve-free: only m1_req=1 with m1_lock=1 for 10 cycles → m1_gnt=1 every cycle; burst_cnt saturates at 4 with no forced gap.
